// File: rtl/ram_write_ctrl_pkg.sv
// Shared types and constants for the RAM write-port controller.
package ram_write_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_CLEAR = 2'd2
  } state_t;

  // Width of the completed-write counter.
  localparam int unsigned CNT_W = 8;

endpackage : ram_write_ctrl_pkg

// File: rtl/key_press_detect.sv
// Push-button conditioner: 2-flop synchronizer followed by a falling-edge detector.
// Produces one clk-wide press pulse for each high-to-low transition of key_n.
module key_press_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic key_n,
  output logic press
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q,  prev_d;

  // Next values: shift the key through the synchronizer and keep the previous level.
  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Synchronizer and edge registers; reset to "released".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Press is valid for the single cycle where the synchronized key has just dropped.
  always_comb begin
    press = prev_q & ~sync2_q;
  end

endmodule : key_press_detect

// File: rtl/ram_write_ctrl.sv
// Write-port controller for the dual-port RAM: turns key presses into single-cycle
// write strobes and runs a clear sweep that fills every address with FILL_VALUE.
module ram_write_ctrl
  import ram_write_ctrl_pkg::*;
#(
  parameter int unsigned          ADDR_W     = 5,
  parameter int unsigned          DATA_W     = 4,
  parameter logic [DATA_W-1:0]    FILL_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_key_n,
  input  logic              clr_key_n,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic [DATA_W-1:0] sw_data,
  output logic [ADDR_W-1:0] wraddress,
  output logic [DATA_W-1:0] data,
  output logic              wren,
  output logic              busy,
  output logic [CNT_W-1:0]  wr_count
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  logic wr_press;
  logic clr_press;

  state_t              state_q,     state_d;
  logic [ADDR_W-1:0]   wraddress_q, wraddress_d;
  logic [DATA_W-1:0]   data_q,      data_d;
  logic                wren_q,      wren_d;
  logic                busy_q,      busy_d;
  logic [CNT_W-1:0]    wr_count_q,  wr_count_d;

  key_press_detect u_wr_key (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (wr_key_n),
    .press   (wr_press)
  );

  key_press_detect u_clr_key (
    .clk     (clk),
    .reset_n (reset_n),
    .key_n   (clr_key_n),
    .press   (clr_press)
  );

  // State and registered-output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      wraddress_q <= '0;
      data_q      <= '0;
      wren_q      <= 1'b0;
      busy_q      <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      wraddress_q <= wraddress_d;
      data_q      <= data_d;
      wren_q      <= wren_d;
      busy_q      <= busy_d;
      wr_count_q  <= wr_count_d;
    end
  end

  // Next-state logic; clear wins over write, presses outside S_IDLE are dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (clr_press) begin
          state_d = S_CLEAR;
        end else if (wr_press) begin
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        state_d = S_IDLE;
      end
      S_CLEAR: begin
        if (wraddress_q == ADDR_MAX) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output/datapath next values; address and data hold between writes.
  always_comb begin
    wraddress_d = wraddress_q;
    data_d      = data_q;
    wren_d      = wren_q;
    busy_d      = busy_q;
    wr_count_d  = wr_count_q;
    case (state_q)
      S_IDLE: begin
        if (clr_press) begin
          wraddress_d = '0;
          data_d      = FILL_VALUE;
          wren_d      = 1'b1;
          busy_d      = 1'b1;
        end else if (wr_press) begin
          wraddress_d = sw_addr;
          data_d      = sw_data;
          wren_d      = 1'b1;
        end
      end
      S_WRITE: begin
        wren_d     = 1'b0;
        wr_count_d = wr_count_q + CNT_W'(1);
      end
      S_CLEAR: begin
        // The last address stays on the bus; the sweep ends instead of wrapping.
        if (wraddress_q == ADDR_MAX) begin
          wren_d = 1'b0;
          busy_d = 1'b0;
        end else begin
          wraddress_d = wraddress_q + ADDR_W'(1);
        end
      end
      default: begin
        wren_d = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  // Drive ports straight from the flops.
  always_comb begin
    wraddress = wraddress_q;
    data      = data_q;
    wren      = wren_q;
    busy      = busy_q;
    wr_count  = wr_count_q;
  end

endmodule : ram_write_ctrl

// File: tb/tb_ram_write_ctrl.sv
// Self-checking bench for ram_write_ctrl: directed scenarios plus random writes,
// checked against a RAM reference image and a RAM mirror built from observed strobes.
module tb_ram_write_ctrl;

  localparam logic [3:0] FILL = 4'hA;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_key_n;
  logic       clr_key_n;
  logic [4:0] sw_addr;
  logic [3:0] sw_data;
  logic [4:0] wraddress;
  logic [3:0] data;
  logic       wren;
  logic       busy;
  logic [7:0] wr_count;

  int tests = 0;
  int fails = 0;
  int wren_cycles = 0;
  int exp_count = 0;
  logic [3:0] ref_ram [32];
  logic [3:0] mir_ram [32];

  ram_write_ctrl #(.ADDR_W(5), .DATA_W(4), .FILL_VALUE(FILL)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_key_n  (wr_key_n),
    .clr_key_n (clr_key_n),
    .sw_addr   (sw_addr),
    .sw_data   (sw_data),
    .wraddress (wraddress),
    .data      (data),
    .wren      (wren),
    .busy      (busy),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  // RAM mirror: what the RAM would hold, taken from the strobes the DUT emits.
  always @(negedge clk) begin
    if (reset_n && wren === 1'b1) begin
      mir_ram[wraddress] = data;
      wren_cycles = wren_cycles + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_ram(input string tag);
    int bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (mir_ram[i] !== ref_ram[i]) bad++;
    end
    check(tag, bad, 0);
  endtask

  // One write press: key falls just before edge 1, strobe expected after edge 3 only.
  task automatic do_write(input logic [4:0] a, input logic [3:0] d, input int extra_hold);
    int w0;
    @(negedge clk);
    w0 = wren_cycles;
    sw_addr  = a;
    sw_data  = d;
    wr_key_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("wr_wren_on", wren, 1);
    check("wr_addr", wraddress, a);
    check("wr_data", data, d);
    check("wr_busy", busy, 0);
    sw_addr = ~a;
    sw_data = ~d;
    @(negedge clk);
    check("wr_wren_off", wren, 0);
    check("wr_data_hold", data, d);
    check("wr_addr_hold", wraddress, a);
    check("wr_count", wr_count, (exp_count + 1) & 255);
    ref_ram[a] = d;
    exp_count = (exp_count + 1) & 255;
    repeat (extra_hold) @(negedge clk);
    wr_key_n = 1'b1;
    repeat (4) @(negedge clk);
    check("wr_single_pulse", wren_cycles - w0, 1);
  endtask

  // One clear sweep, optionally with both keys together and/or a write press mid-sweep.
  task automatic do_clear(input bit both, input bit mid_write);
    int w0;
    @(negedge clk);
    w0 = wren_cycles;
    clr_key_n = 1'b0;
    if (both) wr_key_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("clr_start_wren", wren, 1);
    check("clr_start_busy", busy, 1);
    check("clr_start_addr", wraddress, 0);
    check("clr_start_data", data, FILL);
    for (int i = 1; i < 32; i++) begin
      @(negedge clk);
      check("clr_sweep_addr", wraddress, i);
      check("clr_sweep_wren", {busy, wren, data}, {2'b11, FILL});
      if (i == 3) begin
        clr_key_n = 1'b1;
        wr_key_n  = 1'b1;
      end
      if (mid_write && i == 10) wr_key_n = 1'b0;
      if (i == 14) wr_key_n = 1'b1;
    end
    @(negedge clk);
    check("clr_end_wren", wren, 0);
    check("clr_end_busy", busy, 0);
    check("clr_end_addr", wraddress, 5'h1F);
    check("clr_count_same", wr_count, exp_count);
    repeat (6) @(negedge clk);
    check("clr_pulse_len", wren_cycles - w0, 32);
    for (int i = 0; i < 32; i++) ref_ram[i] = FILL;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      ref_ram[i] = 4'h0;
      mir_ram[i] = 4'h0;
    end
    reset_n   = 1'b0;
    wr_key_n  = 1'b1;
    clr_key_n = 1'b1;
    sw_addr   = '0;
    sw_data   = '0;

    // 1: reset, then 20 quiet cycles
    repeat (3) @(negedge clk);
    check("rst_outputs", {wren, busy, wraddress, data, wr_count}, 0);
    reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_quiet", {wren, busy, wraddress, data, wr_count}, 0);
    end

    // 2: single write, key held 10 cycles
    do_write(5'h01, 4'h5, 6);
    compare_ram("ram_after_first");

    // 3: directed writes including max address, then random writes
    do_write(5'h02, 4'h3, 0);
    do_write(5'h03, 4'h9, 1);
    do_write(5'h04, 4'hD, 2);
    do_write(5'h1F, 4'hF, 0);
    check("count_after_five", wr_count, 5);
    for (int n = 0; n < 20; n++)
      do_write(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 6)));
    compare_ram("ram_after_writes");

    // 4: clear sweep with an ignored write press mid-sweep
    do_clear(1'b0, 1'b1);
    compare_ram("ram_after_clear");

    // 5: both keys on the same edge
    do_write(5'h07, 4'h6, 0);
    do_clear(1'b1, 1'b0);
    compare_ram("ram_after_both");

    // 6: reset in the middle of a clear at address 0x0A
    for (int n = 0; n < 6; n++)
      do_write(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 0);
    @(negedge clk);
    clr_key_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    repeat (10) @(negedge clk);
    check("abort_at_addr", wraddress, 5'h0A);
    #2 reset_n = 1'b0;
    #1;
    check("abort_outputs", {wren, busy, wraddress, data, wr_count}, 0);
    for (int i = 0; i <= 10; i++) ref_ram[i] = FILL;
    exp_count = 0;
    clr_key_n = 1'b1;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_reset_idle", {wren, busy}, 0);
    compare_ram("ram_after_abort");
    do_write(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 2);
    compare_ram("ram_final");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_ram_write_ctrl
